// File: rtl/addsub_pkg.sv
// addsub_pkg: shared width default, mode encoding and overflow helper for adder_subtractor
package addsub_pkg;
   localparam int ADDSUB_DEFAULT_WIDTH = 4;
   typedef enum logic {ADDSUB_ADD = 1'b0, ADDSUB_SUB = 1'b1} addsub_mode_t;
   function automatic logic addsub_overflow(input logic carry_out, input logic carry_into_msb);
      return carry_out ^ carry_into_msb;
   endfunction
endpackage

// File: rtl/addsub_full_adder.sv
// addsub_full_adder: 1-bit full adder cell of the ripple-carry chain
module addsub_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_subtractor.sv
// adder_subtractor: registered ripple-carry add/subtract with C/V flags; ADDSUB_FLAGS_EN adds Z/N outputs
module adder_subtractor
   import addsub_pkg::*;
#(
   parameter int WIDTH = ADDSUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             M,
   output logic             out_valid,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V
`ifdef ADDSUB_FLAGS_EN
   ,
   output logic             Z,
   output logic             N
`endif
);
   addsub_mode_t     mode;
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;

   assign mode     = addsub_mode_t'(M);
   assign bx       = B ^ {WIDTH{mode == ADDSUB_SUB}};
   assign carry[0] = (mode == ADDSUB_SUB);

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         addsub_full_adder u_fa (
            .a    (A[i]),
            .b    (bx[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
         );
      end
   endgenerate

   // capture result and flags on accepted operations; hold them otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         S         <= '0;
         C         <= 1'b0;
         V         <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
         Z         <= 1'b0;
         N         <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            S <= sum;
            C <= carry[WIDTH];
            V <= addsub_overflow(carry[WIDTH], carry[WIDTH-1]);
`ifdef ADDSUB_FLAGS_EN
            Z <= (sum == '0);
            N <= sum[WIDTH-1];
`endif
         end
      end
   end
endmodule

// File: tb/tb_adder_subtractor.sv
// tb_adder_subtractor: directed and exhaustive checks of adder_subtractor at WIDTH=4
module tb_adder_subtractor;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] A;
   logic [3:0] B;
   logic       M;
   logic       out_valid;
   logic [3:0] S;
   logic       C;
   logic       V;
`ifdef ADDSUB_FLAGS_EN
   logic       Z;
   logic       N;
`endif
   int n_vec = 0;
   int n_err = 0;

   adder_subtractor #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .M         (M),
      .out_valid (out_valid),
      .S         (S),
      .C         (C),
      .V         (V)
`ifdef ADDSUB_FLAGS_EN
      ,
      .Z         (Z),
      .N         (N)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // observed/expected words are packed as {out_valid, C, V, S}
   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic m);
      @(negedge clk);
      in_valid = v;
      A = a;
      B = b;
      M = m;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
      int ua, ub, sa, sb, r, sr;
      logic c, v;
      logic [3:0] s;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      r  = m ? ua - ub : ua + ub;
      sr = m ? sa - sb : sa + sb;
      c  = m ? (ua >= ub) : (r > 15);
      v  = (sr > 7) || (sr < -8);
      s  = 4'(r & 15);
      return {1'b1, c, v, s};
   endfunction

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      A = '0;
      B = '0;
      M = 1'b0;
      #1;
      chk("reset_init", {out_valid, C, V, S}, 7'b0_0_0_0000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 4'b0011, 4'b0100, 0);
      chk("add_3p4", {out_valid, C, V, S}, 7'b1_0_0_0111);
      drive(1, 4'b0111, 4'b0001, 0);
      chk("add_7p1_ovf", {out_valid, C, V, S}, 7'b1_0_1_1000);
      drive(1, 4'b0101, 4'b0011, 1);
      chk("sub_5m3", {out_valid, C, V, S}, 7'b1_1_0_0010);
      drive(1, 4'b0011, 4'b0101, 1);
      chk("sub_3m5", {out_valid, C, V, S}, 7'b1_0_0_1110);
      drive(1, 4'b1000, 4'b0001, 1);
      chk("sub_min_m1", {out_valid, C, V, S}, 7'b1_1_1_0111);
      drive(1, 4'b1111, 4'b0001, 0);
      chk("add_wrap", {out_valid, C, V, S}, 7'b1_1_0_0000);
      drive(1, 4'b1000, 4'b1000, 0);
      chk("add_min_min", {out_valid, C, V, S}, 7'b1_1_1_0000);
      drive(1, 4'b0110, 4'b0000, 1);
      chk("sub_b0", {out_valid, C, V, S}, 7'b1_1_0_0110);
      drive(1, 4'b0000, 4'b1000, 1);
      chk("sub_0_min", {out_valid, C, V, S}, 7'b1_0_1_1000);
      drive(1, 4'b0010, 4'b0010, 0);
      chk("b2b_1", {out_valid, C, V, S}, 7'b1_0_0_0100);
      drive(1, 4'b1001, 4'b0011, 1);
      chk("b2b_2", {out_valid, C, V, S}, 7'b1_1_1_0110);
      drive(1, 4'b0110, 4'b0101, 0);
      chk("b2b_3", {out_valid, C, V, S}, 7'b1_0_1_1011);
      drive(0, 4'b0001, 4'b0001, 0);
      chk("idle_hold", {out_valid, C, V, S}, 7'b0_0_1_1011);
      drive(0, 4'bxxxx, 4'bxxxx, 1'bx);
      chk("idle_x_hold", {out_valid, C, V, S}, 7'b0_0_1_1011);
      drive(1, 4'b0110, 4'b0101, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {out_valid, C, V, S}, 7'b0_0_0_0000);
      @(posedge clk);
      #1;
      chk("reset_discard", {out_valid, C, V, S}, 7'b0_0_0_0000);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post_release_idle", {out_valid, C, V, S}, 7'b0_0_0_0000);
      drive(1, 4'b0001, 4'b0010, 0);
      chk("first_after_reset", {out_valid, C, V, S}, 7'b1_0_0_0011);
`ifdef ADDSUB_FLAGS_EN
      drive(1, 4'b0101, 4'b0101, 1);
      chk("flags_zero", {out_valid, C, V, S}, 7'b1_1_0_0000);
      chk("flags_zero_zn", {5'b0, Z, N}, 7'b0000010);
      drive(1, 4'b0000, 4'b0001, 1);
      chk("flags_neg", {out_valid, C, V, S}, 7'b1_0_0_1111);
      chk("flags_neg_zn", {5'b0, Z, N}, 7'b0000001);
`endif
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int m = 0; m < 2; m++) begin
               drive(1, a[3:0], b[3:0], m[0]);
               chk($sformatf("sweep_%0d_%0d_%0d", a, b, m), {out_valid, C, V, S}, model(a[3:0], b[3:0], m[0]));
            end
         end
      end
      drive(0, 4'b0000, 4'b0000, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/adder_subtractor.md
Name: adder_subtractor

Overview:
- Registered WIDTH-bit two's-complement adder/subtractor with carry and overflow flags, one-cycle latency.
- M selects the operation: M=0 gives A+B, M=1 gives A-B.
- Arithmetic building block of the ALU datapath; feeds the ALU result mux and flag register.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2 and up).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode are valid this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- M  input  1  mode: 0 = add, 1 = subtract
- out_valid  output  1  S/C/V hold the result of an accepted operation
- S  output  WIDTH  sum/difference, modulo 2^WIDTH
- C  output  1  carry out of the MSB (for subtract, 1 = no borrow)
- V  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, S=0, C=0, V=0, out_valid=0, forced immediately without waiting for a clock edge.
- Release of rst_n is synchronous to clk.
- Core function is ripple-carry: Bx = B XOR {WIDTH{M}}; carry-in c0 = M; {C,S} = A + Bx + M.
- V = c[WIDTH] XOR c[WIDTH-1], where c[WIDTH-1] is the carry into the MSB.
  - Equivalent form: operands of the effective addition share a sign and S has the other sign.
- Latency is 1 cycle:
  - on a rising clk edge with in_valid=1, register S, C and V from the current A, B, M, and set out_valid=1;
  - on an edge with in_valid=0, set out_valid=0 and hold S/C/V at their last values.
- No backpressure: every in_valid cycle is accepted, giving full throughput of one result per cycle.
- Back-to-back in_valid cycles produce back-to-back results.
- Boundary conditions:
  - Subtract with B=0: result S=A, C=1, V=0.
  - Most-negative cases: A=1000, B=0001, M=1 gives S=0111, C=1, V=1. A=0000, B=1000, M=1 gives S=1000, C=0, V=1.
  - Unsigned wrap: A=1111, B=0001, M=0 gives S=0000, C=1, V=0.
- Reset asserted mid-stream discards any result registered in the same cycle. The first result after release is the first in_valid edge after release.
- X on A/B/M while in_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro ADDSUB_FLAGS_EN.
- When defined, adds two outputs, both registered together with S under the same in_valid rule and reset to 0:
  - Z (1 bit) = 1 when the registered S is all zeros;
  - N (1 bit) = MSB of the registered S.
- When not defined, the ports Z and N do not exist, and no extra logic is generated.

Decomposition:
- Shared package addsub_pkg holds:
  - ADDSUB_DEFAULT_WIDTH = 4;
  - enum typedef addsub_mode_t {ADDSUB_ADD=1'b0, ADDSUB_SUB=1'b1};
  - a function computing overflow from the two top carries.
- One sub-module, addsub_full_adder, a 1-bit full adder (a, b, cin -> s, cout).
  - It is instantiated WIDTH times in a generate loop to form the carry chain.
  - The top level owns the B inversion, carry-in, V logic and the output registers.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with prior outputs nonzero -> S=0, C=0, V=0, out_valid=0 immediately.
- Add: A=0011, B=0100, M=0, in_valid=1 -> next edge S=0111, C=0, V=0, out_valid=1. Then A=0111, B=0001, M=0 -> S=1000, C=0, V=1.
- Subtract: A=0101, B=0011, M=1 -> S=0010, C=1, V=0. Then A=0011, B=0101, M=1 -> S=1110, C=0, V=0.
- Overflow and wrap edges:
  - A=1000, B=0001, M=1 -> S=0111, C=1, V=1;
  - A=1111, B=0001, M=0 -> S=0000, C=1, V=0;
  - A=1000, B=1000, M=0 -> S=0000, C=1, V=1.
- Valid handling: three back-to-back in_valid cycles with distinct operands, then in_valid=0 -> three consecutive correct results, then out_valid=0 with S/C/V held. Sweep all 512 combinations of A, B, M against a reference model.
- ADDSUB_FLAGS_EN build: A=0101, B=0101, M=1 -> S=0000, Z=1, N=0. A=0000, B=0001, M=1 -> S=1111, Z=0, N=1.
